// File: rtl/qspi_ram_responder.sv
// qspi_ram_responder
// Behavioural QSPI PSRAM responder. It oversamples the initiator's SPI clock in
// the clk48 domain and serves quad reads (0xEB) and quad writes (0x38) from an
// internal byte array. SPI-mode 0x35 enters QPI mode and quad-mode 0xF5 leaves
// it; the mode change takes effect when chip select is released.
// clk48 must run at least 4x the SPI clock.
//
// Ports:
//   clk48           system clock
//   reset_n         asynchronous active-low reset
//   spiram4x0_cs_n  chip select from the initiator, active low
//   spiram4x0_clk   SPI clock from the initiator (mode 0, idle low)
//   spiram4x0_dq_i  data lines sampled from the bus
//   spiram4x0_dq_o  data driven onto the bus (registered)
//   spiram4x0_dq_oe per-line output enable
//   quad_mode       1 = device is in QPI mode
//   cmd_error       one-cycle pulse on an unsupported command
//
// Optional build macro QSPI_RAM_PAGE_WRAP_EN: burst addresses wrap inside a
// 1024-byte page instead of incrementing linearly modulo DEPTH.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | chip select released, waiting for cs_n low
// CMD      | shifting in the 8-bit command (8 bits SPI or 2 nibbles QPI)
// ADDR     | shifting in 6 address nibbles
// DUMMY    | counting dummy rises before the first read nibble
// RDATA    | driving read nibbles on each SPI clock fall
// WDATA    | capturing write nibbles on each SPI clock rise
// IGNORE   | rest of the transaction is ignored, bus stays released

module qspi_ram_responder #(
  parameter int DEPTH        = 65536,
  parameter int DUMMY_CYCLES = 6,
  parameter bit INIT_QUAD    = 1'b0
) (
  input  logic       clk48,
  input  logic       reset_n,
  input  logic       spiram4x0_cs_n,
  input  logic       spiram4x0_clk,
  input  logic [3:0] spiram4x0_dq_i,
  output logic [3:0] spiram4x0_dq_o,
  output logic [3:0] spiram4x0_dq_oe,
  output logic       quad_mode,
  output logic       cmd_error
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [7:0] DUMMY_N = 8'(DUMMY_CYCLES);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CMD    = 3'd1;
  localparam logic [2:0] S_ADDR   = 3'd2;
  localparam logic [2:0] S_DUMMY  = 3'd3;
  localparam logic [2:0] S_RDATA  = 3'd4;
  localparam logic [2:0] S_WDATA  = 3'd5;
  localparam logic [2:0] S_IGNORE = 3'd6;

  // synchronisers and edge-detect history
  logic       cs_meta_q, cs_sync_q, cs_prev_q;
  logic       clk_meta_q, clk_sync_q, clk_prev_q;
  logic [3:0] dq_meta_q, dq_sync_q;

  logic [2:0]    state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [6:0]    shift_q, shift_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          is_wr_q, is_wr_d;
  // RDATA: next fall drives the low nibble. WDATA: high nibble already held.
  logic          half_q, half_d;
  logic [3:0]    wnib_q, wnib_d;
  logic [3:0]    dq_o_q, dq_o_d;
  logic [3:0]    oe_q, oe_d;
  logic          quad_q, quad_d;
  logic          pend_en_q, pend_en_d;
  logic          pend_ex_q, pend_ex_d;
  logic          err_q, err_d;

  logic [7:0]    mem [DEPTH];
  logic [7:0]    mem_rd;
  logic          mem_we;
  logic [7:0]    mem_wd;

  logic          rise, fall, cs_rise;
  logic [7:0]    cmd_code;
  logic          cmd_done;
  logic [AW-1:0] addr_nxt;

  assign rise    = clk_sync_q & ~clk_prev_q;
  assign fall    = ~clk_sync_q & clk_prev_q;
  assign cs_rise = cs_sync_q & ~cs_prev_q;

  assign cmd_code = quad_q ? {shift_q[3:0], dq_sync_q} : {shift_q, dq_sync_q[0]};
  assign cmd_done = quad_q ? (cnt_q == 8'd1) : (cnt_q == 8'd7);

`ifdef QSPI_RAM_PAGE_WRAP_EN
  // Only the in-page bits advance; smaller arrays simply wrap at DEPTH.
  localparam int PW = (AW < 10) ? AW : 10;
  localparam logic [AW-1:0] PAGE_MASK = AW'((64'd1 << PW) - 64'd1);
  assign addr_nxt = (addr_q & ~PAGE_MASK) | ((addr_q + AW'(1)) & PAGE_MASK);
`else
  assign addr_nxt = addr_q + AW'(1);
`endif

  assign mem_rd = mem[addr_q];
  assign mem_wd = {wnib_q, dq_sync_q};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    addr_d    = addr_q;
    is_wr_d   = is_wr_q;
    half_d    = half_q;
    wnib_d    = wnib_q;
    dq_o_d    = dq_o_q;
    oe_d      = oe_q;
    quad_d    = quad_q;
    pend_en_d = pend_en_q;
    pend_ex_d = pend_ex_q;
    err_d     = 1'b0;
    mem_we    = 1'b0;

    if (cs_sync_q) begin
      state_d = S_IDLE;
      oe_d    = 4'h0;
      if (cs_rise) begin
        if (pend_en_q) quad_d = 1'b1;
        if (pend_ex_q) quad_d = 1'b0;
        pend_en_d = 1'b0;
        pend_ex_d = 1'b0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_CMD;
          cnt_d   = 8'd0;
          shift_d = 7'd0;
        end
        S_CMD: if (rise) begin
          shift_d = cmd_code[6:0];
          cnt_d   = cnt_q + 8'd1;
          if (cmd_done) begin
            cnt_d   = 8'd0;
            state_d = S_IGNORE;
            if (quad_q) begin
              case (cmd_code)
                8'hEB: begin state_d = S_ADDR; is_wr_d = 1'b0; end
                8'h38: begin state_d = S_ADDR; is_wr_d = 1'b1; end
                8'hF5: pend_ex_d = 1'b1;
                default: err_d = 1'b1;
              endcase
            end else if (cmd_code == 8'h35) begin
              pend_en_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        S_ADDR: if (rise) begin
          // 24 address bits arrive; the cast keeps only the bits that index the array
          addr_d = AW'({addr_q, dq_sync_q});
          cnt_d  = cnt_q + 8'd1;
          if (cnt_q == 8'd5) begin
            cnt_d   = 8'd0;
            half_d  = 1'b0;
            state_d = is_wr_q ? S_WDATA : S_DUMMY;
          end
        end
        S_DUMMY: begin
          if (cnt_q == DUMMY_N) begin
            if (fall) begin
              dq_o_d  = mem_rd[7:4];
              oe_d    = 4'hF;
              half_d  = 1'b1;
              state_d = S_RDATA;
            end
          end else if (rise) begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        S_RDATA: if (fall) begin
          if (half_q) begin
            dq_o_d = mem_rd[3:0];
            addr_d = addr_nxt;
            half_d = 1'b0;
          end else begin
            dq_o_d = mem_rd[7:4];
            half_d = 1'b1;
          end
        end
        S_WDATA: if (rise) begin
          if (half_q) begin
            mem_we = 1'b1;
            addr_d = addr_nxt;
            half_d = 1'b0;
          end else begin
            wnib_d = dq_sync_q;
            half_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk48 or negedge reset_n) begin
    if (!reset_n) begin
      cs_meta_q  <= 1'b1;
      cs_sync_q  <= 1'b1;
      cs_prev_q  <= 1'b1;
      clk_meta_q <= 1'b0;
      clk_sync_q <= 1'b0;
      clk_prev_q <= 1'b0;
      dq_meta_q  <= 4'h0;
      dq_sync_q  <= 4'h0;
      state_q    <= S_IDLE;
      cnt_q      <= 8'd0;
      shift_q    <= 7'd0;
      addr_q     <= '0;
      is_wr_q    <= 1'b0;
      half_q     <= 1'b0;
      wnib_q     <= 4'h0;
      dq_o_q     <= 4'h0;
      oe_q       <= 4'h0;
      quad_q     <= INIT_QUAD;
      pend_en_q  <= 1'b0;
      pend_ex_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      cs_meta_q  <= spiram4x0_cs_n;
      cs_sync_q  <= cs_meta_q;
      cs_prev_q  <= cs_sync_q;
      clk_meta_q <= spiram4x0_clk;
      clk_sync_q <= clk_meta_q;
      clk_prev_q <= clk_sync_q;
      dq_meta_q  <= spiram4x0_dq_i;
      dq_sync_q  <= dq_meta_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      addr_q     <= addr_d;
      is_wr_q    <= is_wr_d;
      half_q     <= half_d;
      wnib_q     <= wnib_d;
      dq_o_q     <= dq_o_d;
      oe_q       <= oe_d;
      quad_q     <= quad_d;
      pend_en_q  <= pend_en_d;
      pend_ex_q  <= pend_ex_d;
      err_q      <= err_d;
    end
  end

  // array contents are deliberately not reset
  always_ff @(posedge clk48) begin
    if (mem_we) mem[addr_q] <= mem_wd;
  end

  // releasing chip select drops the bus in the same cycle the release is seen
  assign spiram4x0_dq_o  = dq_o_q;
  assign spiram4x0_dq_oe = cs_sync_q ? 4'h0 : oe_q;
  assign quad_mode       = quad_q;
  assign cmd_error       = err_q;

endmodule

// File: tb/tb_qspi_ram_responder.sv
module tb_qspi_ram_responder;

  localparam int DEPTH = 65536;
  localparam int DUMMY = 6;
  localparam int HALF  = 5;

  logic       clk48 = 1'b0;
  logic       reset_n = 1'b0;
  logic       cs_n = 1'b1;
  logic       sclk = 1'b0;
  logic [3:0] dq = 4'h0;
  logic [3:0] dq_o, dq_oe;
  logic       quad_mode, cmd_error;

  qspi_ram_responder #(.DEPTH(DEPTH), .DUMMY_CYCLES(DUMMY), .INIT_QUAD(1'b0)) dut (
    .clk48(clk48), .reset_n(reset_n),
    .spiram4x0_cs_n(cs_n), .spiram4x0_clk(sclk), .spiram4x0_dq_i(dq),
    .spiram4x0_dq_o(dq_o), .spiram4x0_dq_oe(dq_oe),
    .quad_mode(quad_mode), .cmd_error(cmd_error)
  );

  always #5 clk48 = ~clk48;

  int n_cmp = 0;
  int n_mis = 0;
  int err_hi = 0;
  int oe_any = 0;

  always @(posedge clk48) begin
    if (cmd_error === 1'b1) err_hi++;
    if (dq_oe !== 4'h0) oe_any++;
  end

  // reference model: bytes the bench has written, keyed by array address
  bit [7:0] ref_mem [int];
  byte unsigned wbuf [$];

  function automatic int nxt(input int a);
`ifdef QSPI_RAM_PAGE_WRAP_EN
    return (a & ~1023 & (DEPTH - 1)) | ((a + 1) & 1023 & (DEPTH - 1));
`else
    return (a + 1) % DEPTH;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic hp();
    repeat (HALF) @(negedge clk48);
  endtask

  task automatic clk_cycle(input logic [3:0] d);
    dq = d;
    hp(); sclk = 1'b1;
    hp(); sclk = 1'b0;
  endtask

  task automatic begin_tx();
    cs_n = 1'b0;
    hp();
  endtask

  task automatic end_tx();
    hp();
    cs_n = 1'b1;
    repeat (8) @(negedge clk48);
  endtask

  task automatic spi_cmd(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) clk_cycle({3'b000, b[i]});
  endtask

  task automatic quad_cmd(input logic [7:0] b);
    clk_cycle(b[7:4]);
    clk_cycle(b[3:0]);
  endtask

  task automatic send_addr(input logic [23:0] a);
    for (int i = 5; i >= 0; i--) clk_cycle(a[i*4 +: 4]);
  endtask

  task automatic do_write(input logic [23:0] a);
    int p;
    p = int'(a) & (DEPTH - 1);
    begin_tx();
    quad_cmd(8'h38);
    send_addr(a);
    foreach (wbuf[i]) begin
      clk_cycle(wbuf[i][7:4]);
      clk_cycle(wbuf[i][3:0]);
      ref_mem[p] = wbuf[i];
      p = nxt(p);
    end
    end_tx();
  endtask

  // dummy phase; leaves the bus right after the last dummy fall
  task automatic dummy_phase(input string tag);
    for (int d = 0; d < DUMMY; d++) begin
      dq = 4'h0;
      hp(); sclk = 1'b1;
      hp();
      if (d == DUMMY - 1) check({tag, "_dummy_oe"}, 32'(dq_oe), 32'h0);
      sclk = 1'b0;
    end
  endtask

  task automatic read_nibble(output logic [3:0] nib, output logic [3:0] oe);
    hp();
    nib = dq_o;
    oe  = dq_oe;
    sclk = 1'b1;
    hp(); sclk = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [23:0] a, input int n);
    int p;
    logic [3:0] hi, lo, oeh, oel;
    p = int'(a) & (DEPTH - 1);
    begin_tx();
    quad_cmd(8'hEB);
    send_addr(a);
    dummy_phase(tag);
    for (int i = 0; i < n; i++) begin
      read_nibble(hi, oeh);
      read_nibble(lo, oel);
      check({tag, "_oe"}, 32'({oeh, oel}), 32'hFF);
      if (ref_mem.exists(p)) check($sformatf("%s_b%0d", tag, i), 32'({hi, lo}), 32'(ref_mem[p]));
      p = nxt(p);
    end
    end_tx();
    check({tag, "_oe_after_cs"}, 32'(dq_oe), 32'h0);
  endtask

  initial begin
    int e0, o0, a, n;
    logic [3:0] h, oe;

    repeat (4) @(negedge clk48);
    reset_n = 1'b1;
    repeat (4) @(negedge clk48);
    check("rst_dq_o", 32'(dq_o), 32'h0);
    check("rst_dq_oe", 32'(dq_oe), 32'h0);
    check("rst_quad", 32'(quad_mode), 32'h0);
    check("rst_cmd_err", 32'(cmd_error), 32'h0);

    // enter QPI: takes effect only once cs_n is released
    begin_tx();
    spi_cmd(8'h35);
    hp();
    check("quad_before_cs_rise", 32'(quad_mode), 32'h0);
    end_tx();
    check("quad_enter", 32'(quad_mode), 32'h1);

    wbuf = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    do_write(24'h000010);
    do_read("deadbeef", 24'h000010, 4);

    // SPI clock toggles with cs_n high must be harmless
    for (int i = 0; i < 10; i++) begin
      dq = 4'(i); hp(); sclk = ~sclk;
    end
    sclk = 1'b0;
    repeat (8) @(negedge clk48);
    do_read("idle_clk", 24'h000010, 4);

    for (int it = 0; it < 6; it++) begin
      a = int'($urandom_range(24'hFFFFFF, 0));
      n = int'($urandom_range(6, 1));
      wbuf.delete();
      for (int j = 0; j < n; j++) wbuf.push_back(8'($urandom));
      do_write(24'(a));
      do_read($sformatf("rnd%0d", it), 24'(a), n);
    end

    wbuf.delete();
    for (int j = 0; j < 4; j++) wbuf.push_back(8'($urandom));
    do_write(24'h00FFFE);
    do_read("wrap", 24'h00FFFE, 4);
`ifdef QSPI_RAM_PAGE_WRAP_EN
    wbuf = '{8'h3C, 8'hC3, 8'h5A};
    do_write(24'h0003FF);
    do_read("page_wrap", 24'h0003FF, 3);
    do_read("page_base", 24'h000000, 2);
`else
    do_read("wrap_base", 24'h000000, 2);
`endif

    // unsupported quad command
    e0 = err_hi; o0 = oe_any;
    begin_tx();
    quad_cmd(8'h9F);
    for (int j = 0; j < 10; j++) clk_cycle(4'($urandom));
    end_tx();
    check("bad_cmd_pulse", 32'(err_hi - e0), 32'h1);
    check("bad_cmd_oe", 32'(oe_any - o0), 32'h0);
    do_read("after_bad", 24'h000010, 4);

    // trailing odd nibble is dropped
    wbuf = '{8'h11, 8'h22};
    do_write(24'h000020);
    begin_tx();
    quad_cmd(8'h38);
    send_addr(24'h000020);
    clk_cycle(4'hA); clk_cycle(4'h5); clk_cycle(4'h7);
    end_tx();
    ref_mem[32'h20] = 8'hA5;
    do_read("odd_nib", 24'h000020, 2);

    // reset in the middle of a read
    begin_tx();
    quad_cmd(8'hEB);
    send_addr(24'h000010);
    dummy_phase("rst_rd");
    read_nibble(h, oe);
    check("rst_rd_first", 32'(h), 32'(ref_mem[32'h10] >> 4));
    hp();
    check("rst_rd_oe_before", 32'(dq_oe), 32'hF);
    reset_n = 1'b0;
    #1;
    check("rst_rd_oe_now", 32'(dq_oe), 32'h0);
    check("rst_rd_dq_o_now", 32'(dq_o), 32'h0);
    cs_n = 1'b1;
    repeat (4) @(negedge clk48);
    reset_n = 1'b1;
    repeat (4) @(negedge clk48);
    check("rst_rd_quad", 32'(quad_mode), 32'h0);

    begin_tx(); spi_cmd(8'h35); end_tx();
    check("quad_reenter", 32'(quad_mode), 32'h1);
    do_read("after_rst", 24'h000010, 4);

    begin_tx(); quad_cmd(8'hF5);
    hp();
    check("quad_before_exit", 32'(quad_mode), 32'h1);
    end_tx();
    check("quad_exit", 32'(quad_mode), 32'h0);

    // 0xEB is not a valid SPI-mode command
    e0 = err_hi; o0 = oe_any;
    begin_tx();
    spi_cmd(8'hEB);
    for (int j = 0; j < 16; j++) clk_cycle(4'($urandom));
    end_tx();
    check("spi_eb_pulse", 32'(err_hi - e0), 32'h1);
    check("spi_eb_oe", 32'(oe_any - o0), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/qspi_ram_responder.md
Name: qspi_ram_responder

Overview:
- Synthesizable behavioural model of a QSPI PSRAM device: the responder end of the spiram4x0 bus that the SoC drives as initiator.
- Oversamples the incoming SPI clock in the system clock domain, decodes the command, address, dummy and data phases, and serves reads and writes from an internal byte array.
- Used in simulation benches and FPGA loopback builds in place of the physical SPI RAM.
- Requires clk48 frequency ≥ 4 × spiram clock frequency.

Parameters:
- DEPTH, 65536: byte array size; power of two, 16..2^24.
- DUMMY_CYCLES, 6: SPI clock cycles between the last address nibble and the first read nibble.
- INIT_QUAD, 0: 1 = quad mode is active out of reset.

Ports:
- clk48  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- spiram4x0_cs_n  input  1  chip select from the initiator, active low.
- spiram4x0_clk  input  1  SPI clock from the initiator (idle low, mode 0).
- spiram4x0_dq_i  input  4  data lines sampled from the bus.
- spiram4x0_dq_o  output  4  data driven onto the bus.
- spiram4x0_dq_oe  output  4  per-line output enable.
- quad_mode  output  1  1 = device is in QPI mode.
- cmd_error  output  1  one-cycle pulse when an unsupported command is decoded.

Behaviour:
- Reset values: dq_o = 0, dq_oe = 0, quad_mode = INIT_QUAD, cmd_error = 0, state = IDLE. Array contents are not reset.
- Input synchronisation: cs_n, clk and dq_i each pass through 2-flop synchronisers. Rise and fall of the SPI clock are detected on the synced value.
- Data is sampled on a detected rise.
- Outputs update 1 clk48 cycle after a detected fall; dq_o/dq_oe are registered.
- Synced cs_n high: state forced to IDLE and dq_oe = 0 in the same cycle, from any state.
- States:
  - IDLE: wait for synced cs_n low. Then go to CMD with the bit/nibble counter cleared.
  - CMD, SPI mode: 8 bits on dq_i[0], MSB first.
  - CMD, quad mode: 2 nibbles, high nibble first.
  - Command decode, SPI mode: 0x35 sets a pending quad-enter flag, then IGNORE. Any other code pulses cmd_error, then IGNORE.
  - Command decode, quad mode: 0xEB goes to ADDR (read); 0x38 goes to ADDR (write); 0xF5 sets a pending quad-exit flag, then IGNORE. Any other code pulses cmd_error, then IGNORE.
  - Pending quad-enter/exit flags take effect on synced cs_n rising (quad_mode updates that cycle). They are discarded if reset is asserted first.
  - ADDR: 6 nibbles, MSB first, form a 24-bit address. Bits above log2(DEPTH) are ignored. Then go to DUMMY (read) or WDATA (write).
  - DUMMY: count DUMMY_CYCLES rises. At the fall following the last dummy rise, dq_oe = 4'hF and the high nibble of mem[addr] is driven. Then go to RDATA.
  - RDATA: each fall drives the next nibble, high nibble then low nibble of each byte. The address increments after the low nibble.
  - WDATA: the high nibble is captured on the first rise and the low nibble on the second. The byte is written on the second rise, then the address increments. A trailing odd nibble at cs_n deassert is discarded.
  - IGNORE: all rises are ignored and dq_oe stays 0 until cs_n goes high.
- Address wrap: increments modulo DEPTH (0xFFFF → 0x0000 at DEPTH = 65536) unless the optional feature is enabled.
- Reset asserted mid-transaction: immediate return to IDLE; outputs take their reset values. A partially received byte is not written.
- A spiram4x0_clk edge while cs_n is high has no effect.

Optional Feature:
- Macro: QSPI_RAM_PAGE_WRAP_EN.
- Defined: reads and writes wrap within a 1024-byte page. Address bits [9:0] increment; the upper bits are held (0x3FF → 0x000 within the same page).
- Undefined: linear increment modulo DEPTH, as described above.

Test Plan:
- Reset with INIT_QUAD = 0 → quad_mode = 0, dq_oe = 0. SPI-mode command 0x35, then cs_n high → quad_mode = 1 on the synced cs_n rise.
- Quad write 0x38, address 0x000010, data 0xDE 0xAD 0xBE 0xEF. Then quad read 0xEB at 0x000010 with 6 dummy cycles → nibbles D,E,A,D,B,E,E,F; dq_oe = 4'hF from the fall after the 6th dummy rise.
- Read 4 bytes starting at 0x00FFFE with DEPTH = 65536 → bytes at 0xFFFE, 0xFFFF, 0x0000, 0x0001. With QSPI_RAM_PAGE_WRAP_EN: read 3 bytes from 0x0003FF → bytes at 0x3FF, 0x000, 0x001.
- Quad command 0x9F → cmd_error pulses high for exactly 1 cycle, dq_oe stays 0 for the rest of the transaction, and the array is unchanged.
- Write 0x38 at 0x20 with 3 nibbles 0xA,0x5,0x7, then cs_n high → mem[0x20] = 0xA5 and mem[0x21] unchanged. Assert reset_n low mid-read → dq_oe = 0 within the same cycle.
- Quad command 0xF5, then cs_n high → quad_mode = 0. A subsequent 0xEB sent in SPI mode → cmd_error pulse, no data driven.
